// File: rtl/vga_frame_driver.sv
// 640x480@60 raster generator: issues pixelX/pixelY, delays sync/blank to match the object pipeline, expands RGB332 to 8 bits per channel.
// Define VGA_TESTPATTERN_EN to add a testMode input that swaps RGBIn for eight vertical colour bars.
module vga_frame_driver #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGBIn,
`ifdef VGA_TESTPATTERN_EN
  input  logic        testMode,
`endif
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  vgaR,
  output logic [7:0]  vgaG,
  output logic [7:0]  vgaB,
  output logic        hSync,
  output logic        vSync,
  output logic        blankN
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int BAR_W    = 80;

  typedef struct packed {
    logic       active;
    logic       hs;
    logic       vs;
    logic       tp;
    logic [2:0] bar;
  } stage_t;

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  stage_t      issue;
  stage_t      pipe_q [PIPE_DELAY];
  stage_t      pipe_d [PIPE_DELAY];
  stage_t      last;
  logic        tp_in;
  logic [7:0]  pix;
  logic [7:0]  vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;

`ifdef VGA_TESTPATTERN_EN
  assign tp_in = testMode;
`else
  assign tp_in = 1'b0;
`endif

  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 8'hFF;
      3'd1:    bar_color = 8'hFC;
      3'd2:    bar_color = 8'h1F;
      3'd3:    bar_color = 8'h1C;
      3'd4:    bar_color = 8'hE3;
      3'd5:    bar_color = 8'hE0;
      3'd6:    bar_color = 8'h03;
      default: bar_color = 8'h00;
    endcase
  endfunction

  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == 11'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == 11'(V_TOTAL - 1)) ? '0 : v_cnt_q + 11'd1;
    end
  end

  always_comb begin
    issue        = '0;
    issue.active = (h_cnt_q < 11'(H_ACTIVE)) && (v_cnt_q < 11'(V_ACTIVE));
    issue.hs     = (h_cnt_q >= 11'(HS_START)) && (h_cnt_q <= 11'(HS_END));
    issue.vs     = (v_cnt_q >= 11'(VS_START)) && (v_cnt_q <= 11'(VS_END));
    issue.tp     = tp_in;
    // Lowest bar whose right edge lies beyond hCnt wins; only meaningful while active.
    issue.bar    = 3'd7;
    for (int k = 6; k >= 0; k--) begin
      if (h_cnt_q < 11'((k + 1) * BAR_W)) issue.bar = 3'(k);
    end
  end

  always_comb begin
    pipe_d[0] = issue;
    for (int i = 1; i < PIPE_DELAY; i++) pipe_d[i] = pipe_q[i-1];
  end

  assign last = pipe_q[PIPE_DELAY-1];

  always_comb begin
    pix     = last.tp ? bar_color(last.bar) : RGBIn;
    blank_d = last.active;
    hsync_d = ~last.hs;
    vsync_d = ~last.vs;
    vga_r_d = '0;
    vga_g_d = '0;
    vga_b_d = '0;
    if (last.active) begin
      vga_r_d = {pix[7:5], pix[7:5], pix[7:6]};
      vga_g_d = {pix[4:2], pix[4:2], pix[4:3]};
      vga_b_d = {4{pix[1:0]}};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= '0;
      vga_r_q <= '0;
      vga_g_q <= '0;
      vga_b_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_d[i];
      vga_r_q <= vga_r_d;
      vga_g_q <= vga_g_d;
      vga_b_q <= vga_b_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
    end
  end

  assign pixelX       = h_cnt_q;
  assign pixelY       = v_cnt_q;
  assign startOfFrame = (h_cnt_q == '0) && (v_cnt_q == '0) && resetN;
  assign vgaR         = vga_r_q;
  assign vgaG         = vga_g_q;
  assign vgaB         = vga_b_q;
  assign hSync        = hsync_q;
  assign vSync        = vsync_q;
  assign blankN       = blank_q;

endmodule

// File: tb/tb_vga_frame_driver.sv
// Directed bench: full-size raster for line/alignment/reset behaviour, plus a shrunken raster for frame/vsync/wrap behaviour.
`timescale 1ns/1ps
module tb_vga_frame_driver;

  logic        clk = 1'b0;
  logic        resetN;
  logic [7:0]  rgb_in;
  logic        test_mode;
  logic [10:0] pixel_x, pixel_y;
  logic        sof, h_sync, v_sync, blank_n;
  logic [7:0]  vga_r, vga_g, vga_b;

  logic [7:0]  s_rgb_in;
  logic        s_test_mode;
  logic [10:0] s_px, s_py;
  logic        s_sof, s_hsync, s_vsync, s_blank;
  logic [7:0]  s_r, s_g, s_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vga_frame_driver dut (
    .clk(clk), .resetN(resetN), .RGBIn(rgb_in),
`ifdef VGA_TESTPATTERN_EN
    .testMode(test_mode),
`endif
    .pixelX(pixel_x), .pixelY(pixel_y), .startOfFrame(sof),
    .vgaR(vga_r), .vgaG(vga_g), .vgaB(vga_b),
    .hSync(h_sync), .vSync(v_sync), .blankN(blank_n)
  );

  // 16x8 raster: active 8x4, hs at h 10..12, vs at lines 5..6, frame 128 cycles.
  vga_frame_driver #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(2)
  ) dut_small (
    .clk(clk), .resetN(resetN), .RGBIn(s_rgb_in),
`ifdef VGA_TESTPATTERN_EN
    .testMode(s_test_mode),
`endif
    .pixelX(s_px), .pixelY(s_py), .startOfFrame(s_sof),
    .vgaR(s_r), .vgaG(s_g), .vgaB(s_b),
    .hSync(s_hsync), .vSync(s_vsync), .blankN(s_blank)
  );

  // Objects-mux model: returns a pixel two cycles after its coordinates were issued.
  logic       rgb_mode;
  logic [10:0] hx1, hy1, hx2, hy2;
  always @(posedge clk) begin
    hx1 <= pixel_x;
    hy1 <= pixel_y;
    hx2 <= hx1;
    hy2 <= hy1;
  end
  always_comb begin
    rgb_in = 8'hFF;
    if (rgb_mode) rgb_in = (hx2 == 11'd100 && hy2 == 11'd5) ? 8'hE0 : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    int hs_issue = -1, hs_first = -1, hs_cnt = 0, blank_cnt = 0, color_err = 0;
    int red_cnt = 0, red_c = -1;
    logic [7:0] red_g = 8'hxx, red_b = 8'hxx;
    int s_sof2 = -1, s_vs_cnt = 0, s_vs_first = -1, s_hs_first = -1;
    int hs_gap = -1;

    resetN = 1'b0; rgb_mode = 1'b0; test_mode = 1'b0;
    s_test_mode = 1'b0; s_rgb_in = 8'hFF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_hsync", h_sync, 1);
    check("rst_vsync", v_sync, 1);
    check("rst_blank", blank_n, 0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("rst_xy", {pixel_x, pixel_y}, 0);
    check("rst_sof", sof, 0);

    resetN = 1'b1;
    #1;
    check("sof_release", sof, 1);
    for (int c = 0; c < 4400; c++) begin
      if (c == 1) begin
        check("x_first_edge", pixel_x, 1);
        check("sof_drop", sof, 0);
      end
      if (c == 2) check("flush_blank", blank_n, 0);
      if (c == 3) check("first_pixel", {blank_n, vga_r, vga_g, vga_b}, 25'h1FFFFFF);
      if (pixel_x == 11'd656 && pixel_y == 11'd0 && hs_issue < 0) hs_issue = c;
      if (!h_sync && hs_first < 0) hs_first = c;
      if (c >= 3 && c < 803) begin
        if (!h_sync) hs_cnt++;
        if (blank_n) blank_cnt++;
      end
      if (c < 1600) begin
        if (blank_n ? ({vga_r, vga_g, vga_b} != 24'hFFFFFF) : ({vga_r, vga_g, vga_b} != 24'h0))
          color_err++;
      end
      if (c >= 1600 && vga_r == 8'hFF) begin
        red_cnt++; red_c = c; red_g = vga_g; red_b = vga_b;
      end
      if (c == 1600) rgb_mode = 1'b1;
      if (c > 0 && s_sof && s_sof2 < 0) s_sof2 = c;
      if (c >= 3 && c < 131 && !s_vsync) s_vs_cnt++;
      if (!s_vsync && s_vs_first < 0) s_vs_first = c;
      if (!s_hsync && s_hs_first < 0) s_hs_first = c;
      if (c == 127) check("small_pre_wrap", {s_px, s_py}, {11'd15, 11'd7});
      if (c == 128) check("small_wrap", {s_px, s_py}, 0);
      @(posedge clk);
      @(negedge clk);
    end
    check("hs_issue_cycle", hs_issue, 656);
    check("hs_first_low", hs_first, 659);
    check("hs_width", hs_cnt, 96);
    check("blank_width", blank_cnt, 640);
    check("blank_color_err", color_err, 0);
    check("align_count", red_cnt, 1);
    check("align_cycle", red_c, 4103);
    check("align_gb", {red_g, red_b}, 0);
    check("small_frame", s_sof2, 128);
    check("small_vs_width", s_vs_cnt, 32);
    check("small_vs_first", s_vs_first, 83);
    check("small_hs_first", s_hs_first, 13);

    check("pre_reset_xy", {pixel_x, pixel_y}, {11'd400, 11'd5});
    resetN = 1'b0;
    #1;
    check("mid_rst_xy", {pixel_x, pixel_y}, 0);
    check("mid_rst_out", {h_sync, v_sync, blank_n, vga_r}, {3'b110, 8'h00});
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    test_mode = 1'b1;
    for (int c = 0; c < 700; c++) begin
      if (!h_sync && hs_gap < 0) hs_gap = c;
`ifdef VGA_TESTPATTERN_EN
      if (c == 88) check("tp_bar1", {vga_r, vga_g, vga_b}, 24'hFFFF00);
`endif
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_hs_gap", hs_gap, 659);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
